ex_mem_reg: RTL
===============

EX_MEM_REG -- requirements
Module: ex_mem_reg

Interface
REQ-001 The block SHALL have one clock and one reset: reset is asynchronous and active-low.
REQ-002 The block SHALL have these ports:
- clk_i  in  1  clock; all state updates on its rising edge.
- rst_i  in  1  reset; asynchronous, active-low.
- stall_i  in  1  hold all state this cycle.
- flush_i  in  1  load a bubble this cycle.
- valid_i  in  1  the ID/EX instruction is real, not a bubble.
- ID_EX_WB_i  in  2  [1]=RegWrite, [0]=MemtoReg.
- ID_EX_M_i  in  2  [1]=MemRead, [0]=MemWrite.
- ALU_result_i  in  32  ALU output.
- mux7_data_i  in  32  store data after forwarding mux B.
- mux3_i  in  5  destination register number.
- EX_MEM_WB_o  out  2  registered WB controls; bit[1] feeds forwarding EX_MEM RegWrite.
- EX_MEM_M_o  out  2  registered memory controls.
- EX_MEM_ALU_o  out  32  registered ALU result / address.
- EX_MEM_wdata_o  out  32  registered store data.
- EX_MEM_mux3_o  out  5  registered destination; feeds forwarding EX_MEM Rd.
- valid_o  out  1  the stage holds a real instruction.
- bubble_cnt_o  out  16  bubbles loaded (EX_MEM_STATS_EN only).
- stall_cnt_o  out  16  stalled cycles (EX_MEM_STATS_EN only).

Function
REQ-003 Latency SHALL be exactly one cycle: inputs sampled on edge N appear on the outputs after edge N.
REQ-004 Per-edge priority SHALL be: reset, then flush_i, then stall_i, then normal load.
REQ-005 A normal load (flush_i=0, stall_i=0) SHALL capture all inputs and set valid_o=valid_i.
REQ-006 A normal load with valid_i=0 SHALL zero EX_MEM_WB_o and EX_MEM_M_o; the data fields are captured anyway.
REQ-007 A normal load with mux3_i=0 SHALL force the captured RegWrite (EX_MEM_WB_o[1]) to 0; other fields load unchanged.
REQ-008 A flush SHALL load a bubble:
- valid_o=0, EX_MEM_WB_o=0, EX_MEM_M_o=0, EX_MEM_mux3_o=0.
- EX_MEM_ALU_o and EX_MEM_wdata_o keep their values.
REQ-009 A stall without flush SHALL hold every output unchanged.
REQ-010 flush_i and stall_i asserted together SHALL behave as a flush.
REQ-011 The outputs SHALL be driven directly from registers, with no combinational path from any input to any output.
REQ-012 A stage holding a bubble SHALL never present RegWrite=1, MemRead=1 or MemWrite=1.

Reset
REQ-013 rst_i low SHALL immediately clear every output and counter to 0, independent of clk_i.
REQ-014 Reset asserted during a stall or flush SHALL override both.
REQ-015 On the first rising edge after rst_i rises, the block SHALL resume normal priority with no extra dead cycle.

Configuration
REQ-016 The macro EX_MEM_STATS_EN SHALL compile the statistics counters in or out.
REQ-017 With EX_MEM_STATS_EN defined, the counters SHALL behave as follows:
- bubble_cnt_o increments on each edge where a flush occurs, or a normal load occurs with valid_i=0.
- stall_cnt_o increments on each edge with stall_i=1 and flush_i=0.
- Both saturate at 16'hFFFF (no wrap).
REQ-018 Without EX_MEM_STATS_EN, bubble_cnt_o and stall_cnt_o SHALL be tied to 0 and no counter flops SHALL exist.

Verification
REQ-019 Load: valid_i=1, WB=2'b10, M=2'b00, ALU=32'h0000_0010, mux3=5'd8, one edge -> EX_MEM_WB_o=2'b10, EX_MEM_mux3_o=8, EX_MEM_ALU_o=32'h10, valid_o=1.
REQ-020 Stall: after REQ-019, change inputs to ALU=32'hDEAD_BEEF and mux3=5'd9, stall_i=1 for 3 edges -> outputs still 32'h10 and 8; stall_cnt_o=3 when EX_MEM_STATS_EN is defined.
REQ-021 Flush plus stall together:
- Stimulus: flush_i=1, stall_i=1 while the stage holds WB=2'b11, M=2'b10.
- Response: EX_MEM_WB_o=0, EX_MEM_M_o=0, EX_MEM_mux3_o=0, valid_o=0, EX_MEM_ALU_o unchanged, bubble_cnt_o=1.
REQ-022 Register 0: valid_i=1, WB=2'b10, mux3=5'd0 -> EX_MEM_WB_o=2'b00, EX_MEM_mux3_o=0.
REQ-023 Async reset: drop rst_i mid-cycle while the stage holds valid data -> all outputs and counters are 0 before the next clk_i edge.
REQ-024 Counter saturation: with EX_MEM_STATS_EN, hold stall_i=1 for 65540 edges -> stall_cnt_o=16'hFFFF.

Source files
------------

// File: rtl/ex_mem_reg.sv
// rtl/ex_mem_reg.sv - EX/MEM pipeline register with flush/stall control and optional statistics
//
// Holds the instruction leaving EX for one cycle. Per clock edge the order
// of precedence is reset, flush, stall, then normal load. Every output is a
// flop, so nothing combinational reaches an output from any input.
//
// Optional feature: define EX_MEM_STATS_EN to build the bubble and stall
// counters. Without it, both counter outputs are tied to zero and no
// counter flops exist.
//
// Ports:
//   clk_i           clock, rising edge
//   rst_i           asynchronous active-low reset
//   stall_i         hold all state this cycle
//   flush_i         load a bubble this cycle (wins over stall_i)
//   valid_i         incoming ID/EX instruction is real
//   ID_EX_WB_i      [1]=RegWrite, [0]=MemtoReg
//   ID_EX_M_i       [1]=MemRead,  [0]=MemWrite
//   ALU_result_i    ALU output / memory address
//   mux7_data_i     store data after forwarding mux B
//   mux3_i          destination register number
//   EX_MEM_WB_o     registered WB controls (bit 1 feeds forwarding)
//   EX_MEM_M_o      registered memory controls
//   EX_MEM_ALU_o    registered ALU result / address
//   EX_MEM_wdata_o  registered store data
//   EX_MEM_mux3_o   registered destination register (feeds forwarding)
//   valid_o         stage holds a real instruction
//   bubble_cnt_o    saturating count of bubbles loaded
//   stall_cnt_o     saturating count of stalled cycles
module ex_mem_reg (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic        valid_i,
  input  logic [1:0]  ID_EX_WB_i,
  input  logic [1:0]  ID_EX_M_i,
  input  logic [31:0] ALU_result_i,
  input  logic [31:0] mux7_data_i,
  input  logic [4:0]  mux3_i,
  output logic [1:0]  EX_MEM_WB_o,
  output logic [1:0]  EX_MEM_M_o,
  output logic [31:0] EX_MEM_ALU_o,
  output logic [31:0] EX_MEM_wdata_o,
  output logic [4:0]  EX_MEM_mux3_o,
  output logic        valid_o,
  output logic [15:0] bubble_cnt_o,
  output logic [15:0] stall_cnt_o
);

  // A write to r0 is architecturally a no-op; dropping RegWrite here keeps
  // the forwarding unit from ever matching on register 0.
  logic reg_write_in;
  assign reg_write_in = ID_EX_WB_i[1] & (mux3_i != 5'd0);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      valid_o        <= 1'b0;
      EX_MEM_WB_o    <= 2'b00;
      EX_MEM_M_o     <= 2'b00;
      EX_MEM_ALU_o   <= 32'd0;
      EX_MEM_wdata_o <= 32'd0;
      EX_MEM_mux3_o  <= 5'd0;
    end else if (flush_i) begin
      // Bubble: kill every side effect, leave the data path as it was.
      valid_o       <= 1'b0;
      EX_MEM_WB_o   <= 2'b00;
      EX_MEM_M_o    <= 2'b00;
      EX_MEM_mux3_o <= 5'd0;
    end else if (!stall_i) begin
      valid_o        <= valid_i;
      // Controls of a non-valid instruction are suppressed so a bubble can
      // never write a register or touch memory; data still loads.
      EX_MEM_WB_o    <= valid_i ? {reg_write_in, ID_EX_WB_i[0]} : 2'b00;
      EX_MEM_M_o     <= valid_i ? ID_EX_M_i : 2'b00;
      EX_MEM_ALU_o   <= ALU_result_i;
      EX_MEM_wdata_o <= mux7_data_i;
      EX_MEM_mux3_o  <= mux3_i;
    end
  end

`ifdef EX_MEM_STATS_EN
  logic bubble_evt;
  logic stall_evt;
  assign bubble_evt = flush_i | (~stall_i & ~valid_i);
  assign stall_evt  = stall_i & ~flush_i;

  // Counters saturate rather than wrap so a long run never reads as short.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      bubble_cnt_o <= 16'd0;
      stall_cnt_o  <= 16'd0;
    end else begin
      if (bubble_evt && (bubble_cnt_o != 16'hFFFF)) begin
        bubble_cnt_o <= bubble_cnt_o + 16'd1;
      end
      if (stall_evt && (stall_cnt_o != 16'hFFFF)) begin
        stall_cnt_o <= stall_cnt_o + 16'd1;
      end
    end
  end
`else
  assign bubble_cnt_o = 16'd0;
  assign stall_cnt_o  = 16'd0;
`endif

endmodule
